// File: rtl/sc_imem_loader.sv
// Loads a length-prefixed program from a byte stream into instruction memory and holds the CPU meanwhile.
// Define LOADER_CHKSUM_EN to add a trailing XOR checksum byte check (CHK state).
module sc_imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_im_we,
  output logic [ADDR_W-1:0] o_im_addr,
  output logic [31:0]       o_im_wdata,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W:0]   o_word_count,
  output logic [2:0]        o_state
);

  // Handshake: a byte moves on a rising edge where i_rx_valid && o_rx_ready;
  // o_rx_ready depends only on the current state, never on i_rx_valid.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
`ifdef LOADER_CHKSUM_EN
    S_CHK   = 3'd4,
`endif
    S_DONE  = 3'd5
  } state_t;

  localparam logic [8:0] MAX_WORDS = 9'(2 ** ADDR_W);

  state_t              r_state;
  state_t              w_next_state;
  logic [7:0]          r_len;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_word_count;
  logic [1:0]          r_byte_cnt;
  logic [31:0]         r_asm;
  logic [ADDR_W-1:0]   r_im_addr;
  logic [31:0]         r_im_wdata;
  logic                r_err;
`ifdef LOADER_CHKSUM_EN
  logic [7:0]          r_chk;
`endif

  logic                w_accept;
  logic                w_start_ok;
  logic                w_len_big;
  logic [ADDR_W:0]     w_wc_next;
  logic                w_last;
  logic [31:0]         w_asm_next;

  assign w_accept   = i_rx_valid && o_rx_ready;
  assign w_start_ok = i_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_len_big  = {1'b0, i_rx_data} > MAX_WORDS;
  assign w_wc_next  = r_word_count + 1'b1;
  assign w_last     = (9'(w_wc_next) == {1'b0, r_len});
  assign w_asm_next = {r_asm[23:0], i_rx_data};

  assign o_im_addr    = r_im_addr;
  assign o_im_wdata   = r_im_wdata;
  assign o_err        = r_err;
  assign o_word_count = r_word_count;
  assign o_done       = (r_state == S_DONE);
  assign o_state      = r_state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    o_rx_ready   = 1'b0;
    o_im_we      = 1'b0;
    o_cpu_hold   = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_next_state = S_LEN;
      S_LEN: begin
        o_rx_ready = 1'b1;
        o_cpu_hold = 1'b1;
        if (i_rx_valid)
          w_next_state = (i_rx_data == 8'd0 || w_len_big) ? S_DONE : S_DATA;
      end
      S_DATA: begin
        o_rx_ready = 1'b1;
        o_cpu_hold = 1'b1;
        if (i_rx_valid && r_byte_cnt == 2'd3) w_next_state = S_WRITE;
      end
      S_WRITE: begin
        o_im_we    = 1'b1;
        o_cpu_hold = 1'b1;
`ifdef LOADER_CHKSUM_EN
        w_next_state = w_last ? S_CHK : S_DATA;
`else
        w_next_state = w_last ? S_DONE : S_DATA;
`endif
      end
`ifdef LOADER_CHKSUM_EN
      S_CHK: begin
        o_rx_ready = 1'b1;
        o_cpu_hold = 1'b1;
        if (i_rx_valid) w_next_state = S_DONE;
      end
`endif
      S_DONE: if (i_start) w_next_state = S_LEN;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Write address/data are captured on the last data byte so they hold steady outside WRITE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_len        <= '0;
      r_addr       <= '0;
      r_word_count <= '0;
      r_byte_cnt   <= '0;
      r_asm        <= '0;
      r_im_addr    <= '0;
      r_im_wdata   <= '0;
      r_err        <= 1'b0;
`ifdef LOADER_CHKSUM_EN
      r_chk        <= '0;
`endif
    end else if (w_start_ok) begin
      r_addr       <= '0;
      r_word_count <= '0;
      r_byte_cnt   <= '0;
      r_asm        <= '0;
      r_err        <= 1'b0;
`ifdef LOADER_CHKSUM_EN
      r_chk        <= '0;
`endif
    end else if (w_accept && r_state == S_LEN) begin
      r_len <= i_rx_data;
      if (w_len_big) r_err <= 1'b1;
    end else if (w_accept && r_state == S_DATA) begin
      r_asm      <= w_asm_next;
      r_byte_cnt <= r_byte_cnt + 1'b1;
`ifdef LOADER_CHKSUM_EN
      r_chk      <= r_chk ^ i_rx_data;
`endif
      if (r_byte_cnt == 2'd3) begin
        r_im_wdata <= w_asm_next;
        r_im_addr  <= r_addr;
      end
    end else if (r_state == S_WRITE) begin
      r_addr       <= r_addr + 1'b1;
      r_word_count <= w_wc_next;
    end
`ifdef LOADER_CHKSUM_EN
    else if (w_accept && r_state == S_CHK) begin
      if (i_rx_data != r_chk) r_err <= 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_sc_imem_loader.sv
// Directed self-checking bench for sc_imem_loader (ADDR_W=6); honours LOADER_CHKSUM_EN when defined.
module tb_sc_imem_loader;
  localparam int ADDR_W = 6;
  localparam int W = ADDR_W + 32;

  logic              clk;
  logic              rst;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;
  logic [2:0]        state;

  logic [W-1:0] exp_q[$];
  int n_cmp;
  int n_err;
  int n_we;
  int cyc;
  int cyc_a;
  logic [7:0] tb_chk;

  sc_imem_loader #(.ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_rx_data(rx_data),
    .i_rx_valid(rx_valid), .o_rx_ready(rx_ready), .o_im_we(im_we),
    .o_im_addr(im_addr), .o_im_wdata(im_wdata), .o_cpu_hold(cpu_hold),
    .o_done(done), .o_err(err), .o_word_count(word_count), .o_state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe is matched against the expected queue
  always @(negedge clk) begin
    if (!rst && im_we) begin
      logic [W-1:0] e;
      n_we++;
      check("ready_in_write", 64'(rx_ready), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(im_addr), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(im_addr), 64'(e[W-1:32]));
        check("wr_data", 64'(im_wdata), 64'(e[31:0]));
      end
    end
  end

  // driver tasks
  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tb_chk = 8'h00;
    cyc_a = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int k;
    rx_valid = 1'b0;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    for (k = 0; k < 40; k++) begin
      if (rx_ready) break;
      @(negedge clk);
    end
    if (k == 40) check("ready_timeout", 64'(rx_ready), 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8], gap_max);
      tb_chk = tb_chk ^ w[i*8 +: 8];
    end
  endtask

  task automatic send_chk(input int gap_max);
`ifdef LOADER_CHKSUM_EN
    send_byte(tb_chk, gap_max);
`else
    if (gap_max < 0) send_byte(tb_chk, 0);
`endif
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 60; k++) begin
      if (done) break;
      @(negedge clk);
    end
    check("done_seen", 64'(done), 64'd1);
  endtask

  initial begin
    logic [31:0] w;
    int we0;
    n_cmp = 0; n_err = 0; n_we = 0; cyc = 0; cyc_a = 0; tb_chk = 8'h00;
    rst = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(rx_ready), 64'd0);
    check("rst_we", 64'(im_we), 64'd0);
    check("rst_addr", 64'(im_addr), 64'd0);
    check("rst_wdata", 64'(im_wdata), 64'd0);
    check("rst_hold", 64'(cpu_hold), 64'd0);
    check("rst_done_err", 64'({done, err}), 64'd0);
    check("rst_wc", 64'(word_count), 64'd0);
    rst = 1'b0;

    // two-word back-to-back load
    start_pulse();
    check("hold_in_len", 64'(cpu_hold), 64'd1);
    check("state_len", 64'(state), 64'd1);
    exp_q.push_back({6'd0, 32'h20010005});
    exp_q.push_back({6'd1, 32'h00000000});
    send_byte(8'h02, 0);
    send_word(32'h20010005, 0);
    send_word(32'h00000000, 0);
    send_chk(0);
    wait_done();
`ifdef LOADER_CHKSUM_EN
    check("a_cycles", 64'(cyc - cyc_a), 64'd12);
`else
    check("a_cycles", 64'(cyc - cyc_a), 64'd11);
`endif
    check("a_err", 64'(err), 64'd0);
    check("a_wc", 64'(word_count), 64'd2);
    check("a_hold", 64'(cpu_hold), 64'd0);
    check("a_n_we", 64'(n_we), 64'd2);
    check("a_addr_hold", 64'(im_addr), 64'd1);
    check("a_data_hold", 64'(im_wdata), 64'd0);

    // zero-length program
    start_pulse();
    send_byte(8'h00, 0);
    check("z_done", 64'(done), 64'd1);
    check("z_err", 64'(err), 64'd0);
    check("z_wc", 64'(word_count), 64'd0);
    check("z_n_we", 64'(n_we), 64'd2);

    // oversize length, then err cleared by next start
    start_pulse();
    send_byte(8'h41, 0);
    check("big_done", 64'(done), 64'd1);
    check("big_err", 64'(err), 64'd1);
    check("big_n_we", 64'(n_we), 64'd2);
    start_pulse();
    check("clr_done_err", 64'({done, err}), 64'd0);

    // full 64-word program
    send_byte(8'h40, 0);
    for (int i = 0; i < 64; i++) begin
      w = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      exp_q.push_back({6'(i), w});
      send_word(w, 0);
    end
    send_chk(0);
    wait_done();
    check("full_err", 64'(err), 64'd0);
    check("full_wc", 64'(word_count), 64'd64);
    check("full_last_addr", 64'(im_addr), 64'd63);
    check("full_n_we", 64'(n_we), 64'd66);
    check("full_q_empty", 64'(exp_q.size()), 64'd0);

    // random rx_valid gaps, plus an ignored start mid-load
    start_pulse();
    exp_q.push_back({6'd0, 32'hDEADBEEF});
    exp_q.push_back({6'd1, 32'h12345678});
    exp_q.push_back({6'd2, 32'hA5A5005A});
    send_byte(8'h03, 3);
    send_word(32'hDEADBEEF, 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_start_state", 64'(state), 64'd2);
    check("ign_start_wc", 64'(word_count), 64'd1);
    send_word(32'h12345678, 3);
    send_word(32'hA5A5005A, 3);
    send_chk(3);
    wait_done();
    check("gap_err", 64'(err), 64'd0);
    check("gap_wc", 64'(word_count), 64'd3);
    check("gap_q_empty", 64'(exp_q.size()), 64'd0);

    // reset mid-load, then reload from address 0
    start_pulse();
    exp_q.push_back({6'd0, 32'h11223344});
    send_byte(8'h02, 0);
    send_word(32'h11223344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_state", 64'(state), 64'd0);
    check("mid_rst_outs", 64'({rx_ready, im_we, cpu_hold, done, err}), 64'd0);
    check("mid_rst_addr", 64'(im_addr), 64'd0);
    check("mid_rst_wdata", 64'(im_wdata), 64'd0);
    check("mid_rst_wc", 64'(word_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    we0 = n_we;
    start_pulse();
    exp_q.push_back({6'd0, 32'hCAFEF00D});
    exp_q.push_back({6'd1, 32'h0BADC0DE});
    send_byte(8'h02, 0);
    send_word(32'hCAFEF00D, 0);
    send_word(32'h0BADC0DE, 0);
    send_chk(0);
    wait_done();
    check("rl_err", 64'(err), 64'd0);
    check("rl_wc", 64'(word_count), 64'd2);
    check("rl_n_we", 64'(n_we - we0), 64'd2);

`ifdef LOADER_CHKSUM_EN
    // bad checksum: word stays written, err raised
    start_pulse();
    exp_q.push_back({6'd0, 32'h8C220004});
    send_byte(8'h01, 0);
    send_word(32'h8C220004, 0);
    send_byte(8'h00, 0);
    check("chk_done", 64'(done), 64'd1);
    check("chk_err", 64'(err), 64'd1);
    check("chk_wc", 64'(word_count), 64'd1);
`endif
    check("final_q_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
